side_ch_iq_pretrig_capture: RTL

- Upstream feeder of the side-channel DMA path.
- Continuously records dual-antenna IQ samples into a pre-trigger ring buffer.
- On a trigger, streams a fixed-length capture, oldest pre-trigger sample first, as 64-bit words. The capture is `iq_len_target` words, of which up to `pre_trigger_len` precede the trigger.
- The word stream drives the `data_to_ps` / `data_to_ps_valid` / `fulln_to_pl` interface of the side-channel m_axis FIFO.

---
 rtl/side_ch_pkg.sv | 21 ++
 rtl/side_ch_pretrig_ram.sv | 30 +++
 rtl/side_ch_iq_pretrig_capture.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/side_ch_pkg.sv
// side_ch_pkg: shared types and constants for the side-channel IQ capture path.
// Holds the capture FSM encoding, the output word packing order and width checks.
package side_ch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARMED  = 2'd1,
    ST_STREAM = 2'd2,
    ST_DONE   = 2'd3
  } cap_state_t;

  localparam int DEF_PRE_BUF_BITS = 10;

  // Output word is {iq1, iq0}: antenna 1 in the upper half.
  localparam bit IQ1_IN_UPPER = 1'b1;

  function automatic bit tdata_width_ok(input int tdata_w, input int iq_w);
    return tdata_w == 4 * iq_w;
  endfunction

endpackage

// File: rtl/side_ch_pretrig_ram.sv
// side_ch_pretrig_ram: simple dual-port pre-trigger ring storage.
// Ports: wr_en/wr_addr/wr_data write port; rd_en/rd_addr -> rd_data one cycle later.
module side_ch_pretrig_ram
  import side_ch_pkg::*;
#(
  parameter int AW = DEF_PRE_BUF_BITS,
  parameter int DW = 64
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);

  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)      rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/side_ch_iq_pretrig_capture.sv
// side_ch_iq_pretrig_capture: pre-trigger ring capture of dual-antenna IQ.
// In: iq0/iq1/iq_strobe, capture_en, trigger, lengths, fulln_to_pl. Out: word stream + status.
module side_ch_iq_pretrig_capture
  import side_ch_pkg::*;
#(
  parameter int IQ_DATA_WIDTH          = 16,
  parameter int C_M_AXIS_TDATA_WIDTH   = 64,
  parameter int MAX_BIT_NUM_DMA_SYMBOL = 14,
  parameter int PRE_BUF_BITS           = DEF_PRE_BUF_BITS
) (
  input  logic                              clk,
  input  logic                              rstn,
  input  logic [2*IQ_DATA_WIDTH-1:0]        iq0,
  input  logic [2*IQ_DATA_WIDTH-1:0]        iq1,
  input  logic                              iq_strobe,
  input  logic                              capture_en,
  input  logic                              trigger,
  input  logic [PRE_BUF_BITS-1:0]           pre_trigger_len,
  input  logic [MAX_BIT_NUM_DMA_SYMBOL-1:0] iq_len_target,
  input  logic                              fulln_to_pl,
  output logic [C_M_AXIS_TDATA_WIDTH-1:0]   data_to_ps,
  output logic                              data_to_ps_valid,
  output logic [1:0]                        capture_state,
  output logic                              capture_done,
  output logic                              overflow,
  output logic [MAX_BIT_NUM_DMA_SYMBOL-1:0] emitted_count
);

  localparam int MB = MAX_BIT_NUM_DMA_SYMBOL;
  localparam int PB = PRE_BUF_BITS;
  localparam int CW = (PB + 1 > MB) ? PB + 1 : MB;
  localparam logic [PB:0] DEPTH = {1'b1, {PB{1'b0}}};

  if (!tdata_width_ok(C_M_AXIS_TDATA_WIDTH, IQ_DATA_WIDTH)) begin : g_bad_width
    $error("C_M_AXIS_TDATA_WIDTH must equal 4*IQ_DATA_WIDTH");
  end

  cap_state_t     state_q, next_state;
  logic [PB-1:0]  wr_ptr, rd_ptr;
  logic [PB:0]    occ;
  logic [MB-1:0]  remaining;
  logic [PB-1:0]  pre_q;
  logic [MB-1:0]  target_q;
  logic           rd_valid;

  logic           arm, wr_en, adv_rd, rd_issue, drop;
  logic           rem_load, rem_dec, occ_inc;
  logic [CW-1:0]  pre_w, tgt_w, occ_w, pre_eff;
  logic [MB-1:0]  rem_trig;
  logic [C_M_AXIS_TDATA_WIDTH-1:0] word;

  assign word = IQ1_IN_UPPER ? {iq1, iq0} : {iq0, iq1};

  // pre_eff never exceeds the capture length; compared in a common width
  assign pre_w    = CW'(pre_q);
  assign tgt_w    = CW'(target_q);
  assign occ_w    = CW'(occ);
  assign pre_eff  = (pre_w < tgt_w) ? pre_w : tgt_w;
  assign rem_trig = MB'(tgt_w - occ_w);

  always_comb begin
    next_state = state_q;
    arm        = 1'b0;
    wr_en      = 1'b0;
    adv_rd     = 1'b0;
    rd_issue   = 1'b0;
    drop       = 1'b0;
    rem_load   = 1'b0;
    rem_dec    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (capture_en) begin
          next_state = ST_ARMED;
          arm        = 1'b1;
        end
      end
      ST_ARMED: begin
        if (trigger) begin
          if (target_q == '0) begin
            next_state = ST_DONE;
          end else begin
            next_state = ST_STREAM;
            rem_load   = 1'b1;
            // trigger-cycle strobe is the first post-trigger sample
            wr_en      = iq_strobe && (rem_trig != '0);
          end
        end else if (iq_strobe) begin
          wr_en  = 1'b1;
          adv_rd = (occ_w == pre_eff);
        end
      end
      ST_STREAM: begin
        if (iq_strobe && remaining != '0) begin
          rem_dec = 1'b1;
          if (occ == DEPTH) drop  = 1'b1;
          else              wr_en = 1'b1;
        end
        rd_issue = (occ != '0) && fulln_to_pl;
        if (remaining == '0 && occ == '0 && !rd_valid)
          next_state = ST_DONE;
      end
      ST_DONE: next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
    if (!capture_en) begin
      next_state = ST_IDLE;
      arm        = 1'b0;
      wr_en      = 1'b0;
      adv_rd     = 1'b0;
      rd_issue   = 1'b0;
      drop       = 1'b0;
      rem_load   = 1'b0;
      rem_dec    = 1'b0;
    end
  end

  assign occ_inc = wr_en && !adv_rd;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q       <= ST_IDLE;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      occ           <= '0;
      remaining     <= '0;
      pre_q         <= '0;
      target_q      <= '0;
      rd_valid      <= 1'b0;
      overflow      <= 1'b0;
      emitted_count <= '0;
    end else begin
      state_q  <= next_state;
      rd_valid <= rd_issue;
      if (arm) begin
        wr_ptr        <= '0;
        rd_ptr        <= '0;
        occ           <= '0;
        remaining     <= '0;
        overflow      <= 1'b0;
        emitted_count <= '0;
        pre_q         <= pre_trigger_len;
        target_q      <= iq_len_target;
      end else begin
        if (wr_en)             wr_ptr <= wr_ptr + 1'b1;
        if (adv_rd || rd_issue) rd_ptr <= rd_ptr + 1'b1;
        unique case ({occ_inc, rd_issue})
          2'b10:   occ <= occ + 1'b1;
          2'b01:   occ <= occ - 1'b1;
          default: occ <= occ;
        endcase
        if (rem_load)     remaining <= wr_en ? rem_trig - 1'b1 : rem_trig;
        else if (rem_dec) remaining <= remaining - 1'b1;
        if (drop)     overflow      <= 1'b1;
        if (rd_issue) emitted_count <= emitted_count + 1'b1;
      end
    end
  end

  side_ch_pretrig_ram #(
    .AW (PB),
    .DW (C_M_AXIS_TDATA_WIDTH)
  ) u_ram (
    .clk     (clk),
    .rstn    (rstn),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr),
    .wr_data (word),
    .rd_en   (rd_issue),
    .rd_addr (rd_ptr),
    .rd_data (data_to_ps)
  );

  assign data_to_ps_valid = rd_valid;
  assign capture_state    = state_q;
  assign capture_done     = (state_q == ST_DONE);

endmodule
